// File: rtl/width_16to8_fifo.sv
// Buffers 16-bit words from a valid-only source in a small FIFO and replays
// each one as two bytes (high byte first) on a valid/ready byte interface.
module width_16to8_fifo #(
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid_in,
  input  logic [15:0]   data_in,
  input  logic          ready_in,
  output logic          valid_out,
  output logic [7:0]    data_out,
  output logic [AW:0]   level,
  output logic          overflow
);

  localparam int Depth = 1 << AW;
  localparam logic [AW:0] DepthLvl = (AW+1)'(Depth);

  typedef enum logic [1:0] {IDLE, HI, LO} state_e;

  state_e          state_q;
  logic [15:0]     mem_q [Depth];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [AW:0]     level_q, level_d;
  logic            overflow_q;
  logic            validOut_q;
  logic [7:0]      dataOut_q;
  logic [7:0]      shadow_q;

  logic            xfer, hasWord, full, pop, push;
  logic [15:0]     popWord;

  assign xfer    = validOut_q && ready_in;
  assign hasWord = level_q != '0;
  assign full    = level_q == DepthLvl;
  assign pop     = hasWord && ((state_q == IDLE) || (state_q == LO && xfer));
  // A full FIFO still takes a word when the serializer drains one in the same cycle.
  assign push    = valid_in && (!full || pop);
  assign popWord = mem_q[rptr_q];

  always_comb begin
    level_d = level_q;
    if (push && !pop)
      level_d = level_q + 1'b1;
    else if (!push && pop)
      level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wptr_q] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      validOut_q <= 1'b0;
      dataOut_q  <= '0;
      shadow_q   <= '0;
    end else begin
      level_q <= level_d;
      if (push)
        wptr_q <= wptr_q + 1'b1;
      if (pop)
        rptr_q <= rptr_q + 1'b1;
      if (valid_in && !push)
        overflow_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (pop) begin
            shadow_q   <= popWord[7:0];
            dataOut_q  <= popWord[15:8];
            validOut_q <= 1'b1;
            state_q    <= HI;
          end else begin
            validOut_q <= 1'b0;
          end
        end
        HI: begin
          if (xfer) begin
            dataOut_q <= shadow_q;
            state_q   <= LO;
          end
        end
        LO: begin
          // Chain straight into the next word so back-to-back words have no bubble.
          if (xfer) begin
            if (pop) begin
              shadow_q  <= popWord[7:0];
              dataOut_q <= popWord[15:8];
              state_q   <= HI;
            end else begin
              validOut_q <= 1'b0;
              state_q    <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign valid_out = validOut_q;
  assign data_out  = dataOut_q;
  assign level     = level_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_width_16to8_fifo.sv
// Directed bench for width_16to8_fifo: hand-computed byte streams, levels and
// overflow behaviour across fill, stall, full push/pop and mid-transfer reset.
module tb_width_16to8_fifo;

  localparam int AW = 2;

  logic          clk;
  logic          rst_n;
  logic          valid_in;
  logic [15:0]   data_in;
  logic          ready_in;
  logic          valid_out;
  logic [7:0]    data_out;
  logic [AW:0]   level;
  logic          overflow;

  int nCompared;
  int nMismatched;

  logic [7:0] fillBytes [10] = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33,
                                 8'h33, 8'h44, 8'h44, 8'h55, 8'h55};
  logic [7:0] fullBytes [10] = '{8'hB1, 8'hB2, 8'hC1, 8'hC2, 8'hD1,
                                 8'hD2, 8'hE1, 8'hE2, 8'hF1, 8'hF2};
  logic [7:0] rateBytes [8]  = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                                 8'h05, 8'h06, 8'h06};
  logic       rateValid [8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [AW:0] rateLevel [8] = '{3'd1, 3'd0, 3'd1, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0};
  logic       stallReady [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] stallBytes [5] = '{8'hBE, 8'hBE, 8'hEF, 8'hEF, 8'hEF};
  logic       stallValid [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  width_16to8_fifo #(.AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_in  (ready_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .level     (level),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic r);
    valid_in = v;
    data_in  = d;
    ready_in = r;
  endtask

  // Advance one clock and settle just past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 16'h0000, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    rst_n       = 1'b1;
    applyStimulus(1'b0, 16'h0000, 1'b0);
    #2;
    doReset();

    checkOutput("rst_valid", valid_out, 0);
    checkOutput("rst_data", data_out, 0);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_ovf", overflow, 0);

    // Single word
    applyStimulus(1'b1, 16'hA55A, 1'b1);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("single_lvl1", level, 1);
    checkOutput("single_nv", valid_out, 0);
    tick();
    checkOutput("single_hi_v", valid_out, 1);
    checkOutput("single_hi_d", data_out, 8'hA5);
    checkOutput("single_lvl0", level, 0);
    tick();
    checkOutput("single_lo_v", valid_out, 1);
    checkOutput("single_lo_d", data_out, 8'h5A);
    tick();
    checkOutput("single_end_v", valid_out, 0);
    checkOutput("single_ovf", overflow, 0);

    // Sustained rate: one word every 2 cycles
    for (int k = 0; k < 8; k++) begin
      case (k)
        0: applyStimulus(1'b1, 16'h0102, 1'b1);
        2: applyStimulus(1'b1, 16'h0304, 1'b1);
        4: applyStimulus(1'b1, 16'h0506, 1'b1);
        default: applyStimulus(1'b0, 16'h0000, 1'b1);
      endcase
      tick();
      checkOutput($sformatf("rate_v%0d", k), valid_out, rateValid[k]);
      if (rateValid[k])
        checkOutput($sformatf("rate_d%0d", k), data_out, rateBytes[k]);
      checkOutput($sformatf("rate_lvl%0d", k), level, rateLevel[k]);
    end
    checkOutput("rate_ovf", overflow, 0);

    // Fill and overflow
    for (int k = 0; k < 12; k++) begin
      if (k % 2 == 0)
        applyStimulus(1'b1, 16'h1111 * (k/2 + 1), 1'b0);
      else
        applyStimulus(1'b0, 16'h0000, 1'b0);
      tick();
      if (k == 8)
        checkOutput("fill_ovf_before", overflow, 0);
    end
    checkOutput("fill_lvl", level, 4);
    checkOutput("fill_ovf", overflow, 1);
    checkOutput("fill_hold_v", valid_out, 1);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    for (int j = 0; j < 10; j++) begin
      checkOutput($sformatf("drain_v%0d", j), valid_out, 1);
      checkOutput($sformatf("drain_d%0d", j), data_out, fillBytes[j]);
      tick();
    end
    checkOutput("drain_end_v", valid_out, 0);
    checkOutput("drain_ovf", overflow, 1);

    // Stall hold
    applyStimulus(1'b1, 16'hBEEF, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0);
    tick();
    checkOutput("stall_first", data_out, 8'hBE);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 16'h0000, stallReady[k]);
      tick();
      checkOutput($sformatf("stall_v%0d", k), valid_out, stallValid[k]);
      checkOutput($sformatf("stall_d%0d", k), data_out, stallBytes[k]);
    end

    // Full FIFO with simultaneous push and pop
    doReset();
    applyStimulus(1'b1, 16'hA1A2, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0);
    tick();
    applyStimulus(1'b1, 16'hB1B2, 1'b1);
    tick();
    applyStimulus(1'b1, 16'hC1C2, 1'b0);
    tick();
    applyStimulus(1'b1, 16'hD1D2, 1'b0);
    tick();
    applyStimulus(1'b1, 16'hE1E2, 1'b0);
    tick();
    checkOutput("full_lvl", level, 4);
    checkOutput("full_lo_d", data_out, 8'hA2);
    applyStimulus(1'b1, 16'hF1F2, 1'b1);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("full_pp_lvl", level, 4);
    checkOutput("full_pp_ovf", overflow, 0);
    for (int j = 0; j < 10; j++) begin
      checkOutput($sformatf("full_v%0d", j), valid_out, 1);
      checkOutput($sformatf("full_d%0d", j), data_out, fullBytes[j]);
      tick();
    end
    checkOutput("full_end_v", valid_out, 0);
    checkOutput("full_end_ovf", overflow, 0);

    // Reset mid-transfer
    applyStimulus(1'b1, 16'h7788, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 16'h9900 + 16'(k), 1'b0);
      tick();
    end
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("mid_pre_lvl", level, 3);
    checkOutput("mid_pre_v", valid_out, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_v", valid_out, 0);
    checkOutput("mid_rst_d", data_out, 0);
    checkOutput("mid_rst_lvl", level, 0);
    checkOutput("mid_rst_ovf", overflow, 0);
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b0, 16'h0000, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput($sformatf("post_idle_v%0d", k), valid_out, 0);
    end
    applyStimulus(1'b1, 16'h1234, 1'b1);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("post_lvl", level, 1);
    tick();
    checkOutput("post_hi_v", valid_out, 1);
    checkOutput("post_hi_d", data_out, 8'h12);
    tick();
    checkOutput("post_lo_d", data_out, 8'h34);
    tick();
    checkOutput("post_end_v", valid_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/width_16to8_fifo.md
# width_16to8_fifo

Downstream stage for the 8-to-16 width converter. It accepts 16-bit words on a valid-only interface with no backpressure and buffers them in a small FIFO. It then serializes each word into two bytes, high byte first, on a valid/ready output interface. A sticky flag reports words dropped because the buffer was full.

## Interface
- AW, 2: FIFO address width; FIFO depth is 2^AW words (AW ≥ 1).
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- valid_in  input  1  data_in carries a word this cycle; single-cycle pulse per word, no backpressure.
- data_in  input  16  word; [15:8] is the earlier byte, [7:0] the later byte.
- ready_in  input  1  downstream can accept a byte this cycle.
- valid_out  output  1  data_out holds a valid byte.
- data_out  output  8  output byte.
- level  output  AW+1  words stored in the FIFO, excluding the word held by the serializer.
- overflow  output  1  sticky: a word was dropped since reset.

## Operation
- **Reset (rst_n low).** Takes effect immediately and asynchronously:
  - valid_out=0, data_out=0, level=0, overflow=0.
  - Read/write pointers are 0, the serializer is in IDLE, and the shadow register is 0.
- **FIFO write.** When valid_in=1 and the FIFO is not full, data_in is written at wptr and wptr increments, wrapping modulo 2^AW.
  - Full means level == 2^AW, evaluated before this cycle's pop.
  - Full + valid_in + pop in the same cycle: the push is accepted and level is unchanged.
  - Full + valid_in without a pop: the word is dropped and overflow is set to 1 until reset.
- **FIFO read (pop).** Reads the word at rptr and increments rptr, wrapping. A pop happens only on the serializer transitions listed below.
- **level update.** Next level = level + push − pop. It never exceeds 2^AW and never goes below 0.
- **Serializer FSM.** A byte transfers when valid_out && ready_in. Transitions:
  - IDLE: if level > 0, pop. Load word[7:0] into the shadow register, set data_out=word[15:8], valid_out=1, and go to HI. Otherwise stay in IDLE with valid_out=0.
  - HI: on a transfer, set data_out=shadow and go to LO. Otherwise hold.
  - LO, on a transfer with level > 0: pop the next word, set data_out=next[15:8], and go to HI. There is no bubble between words.
  - LO, on a transfer with level == 0: set valid_out=0 and go to IDLE. data_out keeps its last value.
  - LO, without a transfer: hold.
- **Stall rule.** While valid_out=1 and ready_in=0, data_out and valid_out are held stable.
- **Output ordering.** Bytes leave in word order. Within each word, the high byte goes before the low byte.
- **Capacity.** Total storage is 2^AW + 1 words: the FIFO plus one word in the serializer.

## Timing
- Word sampled with valid_in at edge E: level increments after E. If the FIFO was empty and the serializer IDLE, the pop occurs at E+1 and the high byte is valid after E+1. Latency is 2 cycles from valid_in to the first valid_out.
- With ready_in=1, the low byte follows one cycle after the high byte.
- Sustained throughput is 1 byte/cycle, i.e. one word per 2 cycles. This matches the upstream maximum of one word per 2 cycles, so no overflow occurs while ready_in is held at 1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Single word.** Reset, then a single valid_in with 0xA55A, ready_in=1.
  - Required: valid_out=1 with data_out=0xA5 two cycles later, then 0x5A, then valid_out=0.
  - level goes 1→0 and overflow stays 0.
- **Sustained rate.** Words 0x0102, 0x0304, 0x0506 at a 2-cycle spacing, ready_in=1.
  - Required: unbroken byte stream 01,02,03,04,05,06 with valid_out continuously high for 6 cycles.
  - level ≤ 1 throughout and overflow=0.
- **Fill and overflow (AW=2).** ready_in=0; write words 0x1111 … 0x6666 at a 2-cycle spacing.
  - Required: words 1–5 accepted, level=4, and the 6th word dropped with overflow=1.
  - Then ready_in=1: exactly 10 bytes 11,11,22,22,…,55,55, then valid_out=0. overflow stays 1.
- **Stall hold.** One word 0xBEEF with ready_in toggling 0,0,1,0,1.
  - Required: data_out=0xBE held through the stall cycles; 0xEF appears after the first accept and is held until the second accept.
- **Full with simultaneous push and pop.** FIFO full (level=4) with the serializer in LO; apply ready_in=1 and valid_in=1 in the same cycle.
  - Required: the new word is accepted, level stays 4, overflow=0, and output order is preserved.
- **Reset mid-transfer.** Assert rst_n low while valid_out=1 with 3 words buffered.
  - Required: valid_out, data_out, level and overflow go to 0 immediately.
  - After release, no stale bytes are emitted; a new word 0x1234 produces 0x12, 0x34.
